// File: rtl/decoder_rr_arbiter4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface decoder_rr_arbiter4_if;
  logic [3:0] req;
  logic       gnt_valid;
  logic [1:0] gnt_sel;
  logic [3:0] gnt_onehot;
  logic       preempt;

  modport master (output req, input gnt_valid, gnt_sel, gnt_onehot, preempt);
  modport slave  (input req, output gnt_valid, gnt_sel, gnt_onehot, preempt);
endinterface

// File: rtl/decoder_rr_arbiter4.sv
// Four-way round-robin arbiter with registered select + one-hot grant; ARB_TIMEOUT_EN adds hold-time preemption.
// Latency: grant visible one cycle after req is sampled; handovers are back-to-back.
// Backpressure: none; a holder keeps the grant while req is high (until HOLD_MAX cycles if preemption is built in).
module decoder_rr_arbiter4 #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  decoder_rr_arbiter4_if.slave  arb
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  if (HOLD_MAX < 1 || HOLD_MAX > (2**CNT_W) - 1) begin : g_hold_max_range
    $error("HOLD_MAX does not fit in CNT_W bits");
  end

  logic [0:0] state, nxt_state;
  logic [1:0] ptr;
  logic       valid_q, nxt_valid;
  logic [1:0] sel_q, nxt_sel;
  logic [3:0] onehot_q;
  logic       preempt_q, nxt_preempt;
  logic       take;
  logic [3:0] others;

  // First set bit of r, scanning start, start+1, ... mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign others = arb.req & ~onehot_q;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  logic [CNT_W-1:0] hold_cnt;
  logic             timeout;

  assign timeout = (|others) && (hold_cnt >= HOLD_LAST);
`endif

  always_comb begin
    nxt_state   = state;
    nxt_valid   = valid_q;
    nxt_sel     = sel_q;
    nxt_preempt = 1'b0;
    take        = 1'b0;
    case (state)
      IDLE: begin
        if (|arb.req) begin
          take    = 1'b1;
          nxt_sel = rr_pick(arb.req, ptr);
        end
      end
      GRANT: begin
        if (!arb.req[sel_q]) begin
          // The releasing holder is masked out, so it naturally comes last.
          if (|others) begin
            take    = 1'b1;
            nxt_sel = rr_pick(others, sel_q + 2'd1);
          end else begin
            nxt_state = IDLE;
            nxt_valid = 1'b0;
            nxt_sel   = 2'd0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (timeout) begin
          take        = 1'b1;
          nxt_preempt = 1'b1;
          nxt_sel     = rr_pick(others, sel_q + 2'd1);
        end
`endif
      end
      default: begin
        nxt_state = IDLE;
        nxt_valid = 1'b0;
        nxt_sel   = 2'd0;
      end
    endcase
    if (take) begin
      nxt_state = GRANT;
      nxt_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      valid_q   <= 1'b0;
      sel_q     <= 2'd0;
      onehot_q  <= 4'b0000;
      preempt_q <= 1'b0;
    end else begin
      state     <= nxt_state;
      valid_q   <= nxt_valid;
      sel_q     <= nxt_sel;
      onehot_q  <= nxt_valid ? (4'b0001 << nxt_sel) : 4'b0000;
      preempt_q <= nxt_preempt;
      if (take) ptr <= nxt_sel + 2'd1;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (take || nxt_state == IDLE) begin
      hold_cnt <= '0;
    end else if (|others || hold_cnt < HOLD_SAT) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end
`endif

  assign arb.gnt_valid  = valid_q;
  assign arb.gnt_sel    = sel_q;
  assign arb.gnt_onehot = onehot_q;
  assign arb.preempt    = preempt_q;

endmodule

// File: tb/tb_decoder_rr_arbiter4.sv
// Directed, table-driven bench for decoder_rr_arbiter4 (HOLD_MAX=4); expectations follow ARB_TIMEOUT_EN.
module tb_decoder_rr_arbiter4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  decoder_rr_arbiter4_if bus ();

  decoder_rr_arbiter4 #(.HOLD_MAX(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0] req;
    logic       v;
    logic [1:0] sel;
    logic [3:0] oh;
    logic       pre;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(logic [3:0] r, logic v, logic [1:0] s, logic [3:0] oh);
    vec_t t;
    t.req = r; t.v = v; t.sel = s; t.oh = oh; t.pre = 1'b0;
    return t;
  endfunction

  task automatic check(input string name, input logic v, input logic [1:0] s,
                       input logic [3:0] oh, input logic p);
    checks++;
    if (bus.gnt_valid !== v || bus.gnt_sel !== s || bus.gnt_onehot !== oh || bus.preempt !== p) begin
      errors++;
      $display("FAIL %s: got valid=%b sel=%0d onehot=%b preempt=%b, required valid=%b sel=%0d onehot=%b preempt=%b",
               name, bus.gnt_valid, bus.gnt_sel, bus.gnt_onehot, bus.preempt, v, s, oh, p);
    end
  endtask

  task automatic step(input logic [3:0] r);
    @(negedge clk);
    bus.req = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.req = 4'b0000;

    tbl[0]  = mk(4'b0000, 0, 2'd0, 4'b0000);
    tbl[1]  = mk(4'b0000, 0, 2'd0, 4'b0000);
    tbl[2]  = mk(4'b0000, 0, 2'd0, 4'b0000);
    tbl[3]  = mk(4'b0100, 1, 2'd2, 4'b0100);
    tbl[4]  = mk(4'b0100, 1, 2'd2, 4'b0100);
    tbl[5]  = mk(4'b0100, 1, 2'd2, 4'b0100);
    tbl[6]  = mk(4'b0000, 0, 2'd0, 4'b0000);
    tbl[7]  = mk(4'b1111, 1, 2'd3, 4'b1000);
    tbl[8]  = mk(4'b1111, 1, 2'd3, 4'b1000);
    tbl[9]  = mk(4'b0111, 1, 2'd0, 4'b0001);
    tbl[10] = mk(4'b1111, 1, 2'd0, 4'b0001);
    tbl[11] = mk(4'b1110, 1, 2'd1, 4'b0010);
    tbl[12] = mk(4'b1111, 1, 2'd1, 4'b0010);
    tbl[13] = mk(4'b1101, 1, 2'd2, 4'b0100);
    tbl[14] = mk(4'b1111, 1, 2'd2, 4'b0100);
    tbl[15] = mk(4'b1011, 1, 2'd3, 4'b1000);
    tbl[16] = mk(4'b1111, 1, 2'd3, 4'b1000);
    tbl[17] = mk(4'b0011, 1, 2'd0, 4'b0001);
    tbl[18] = mk(4'b0011, 1, 2'd0, 4'b0001);
    tbl[19] = mk(4'b0010, 1, 2'd1, 4'b0010);
    tbl[20] = mk(4'b0010, 1, 2'd1, 4'b0010);
    tbl[21] = mk(4'b0000, 0, 2'd0, 4'b0000);
    tbl[22] = mk(4'b1001, 1, 2'd3, 4'b1000);
    tbl[23] = mk(4'b0000, 0, 2'd0, 4'b0000);
    tbl[24] = mk(4'b1010, 1, 2'd1, 4'b0010);
    tbl[25] = mk(4'b1001, 1, 2'd3, 4'b1000);
    tbl[26] = mk(4'b0000, 0, 2'd0, 4'b0000);

    #3;
    check("reset_state", 0, 2'd0, 4'b0000, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      step(tbl[i].req);
      check($sformatf("vec%0d", i), tbl[i].v, tbl[i].sel, tbl[i].oh, tbl[i].pre);
    end

    // Asynchronous reset in the middle of a grant, then pointer back at 0.
    step(4'b0001);
    check("pre_reset_grant", 1, 2'd0, 4'b0001, 0);
    #2;
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    #1;
    check("async_reset", 0, 2'd0, 4'b0000, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1001);
    check("ptr_after_reset", 1, 2'd0, 4'b0001, 0);
    step(4'b0000);
    check("idle_after_reset", 0, 2'd0, 4'b0000, 0);

    // Requester 1 holds while requester 2 waits.
    step(4'b0010);
    check("hold_grant1", 1, 2'd1, 4'b0010, 0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 5; i++) begin
      step(4'b0110);
      if (i < 3)       check($sformatf("timeout_hold%0d", i), 1, 2'd1, 4'b0010, 0);
      else if (i == 3) check("timeout_preempt", 1, 2'd2, 4'b0100, 1);
      else             check("timeout_after", 1, 2'd2, 4'b0100, 0);
    end
    step(4'b0010);
    check("timeout_regrant1", 1, 2'd1, 4'b0010, 0);
`else
    for (int i = 0; i < 8; i++) begin
      step(4'b0110);
      check($sformatf("no_timeout_hold%0d", i), 1, 2'd1, 4'b0010, 0);
    end
    step(4'b0100);
    check("no_timeout_release", 1, 2'd2, 4'b0100, 0);
`endif
    step(4'b0000);
    check("final_idle", 0, 2'd0, 4'b0000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
